card_dealer: RTL

Deck source for the blackjack datapath. Holds one 52-card deck, shuffles it with an on-chip LFSR, and drives the `card` bus consumed by the game FSM: the 4-card opening deal on `deal`, then single cards on player `hit` and dealer `dhit` requests. Card values are blackjack points (ace = 1, 2–9, 10/J/Q/K = 10). Every dealt card appears as a non-zero value for exactly one clock; `card` is 0 at all other times.

---
 rtl/card_dealer_if.sv | 22 ++
 rtl/card_dealer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/card_dealer_if.sv
// Request/response bus between the card dealer and the blackjack game FSM.
// The game side drives the request pulses; the dealer returns one card per request.
interface card_dealer_if;
   logic       shuffle;
   logic       deal;
   logic       hit;
   logic       dhit;
   logic [3:0] card;
   logic       ready;
   logic       empty;
   logic [5:0] remaining;

   modport master (
      output shuffle, deal, hit, dhit,
      input  card, ready, empty, remaining
   );

   modport slave (
      input  shuffle, deal, hit, dhit,
      output card, ready, empty, remaining
   );
endinterface

// File: rtl/card_dealer.sv
// 52-card deck with LFSR-driven Fisher-Yates shuffle; deals the opening four
// cards on deal and single cards on player/dealer hit requests.
module card_dealer #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter int          GAP  = 2
) (
   input logic          clock,
   input logic          reset,
   card_dealer_if.slave bus
);
   typedef enum logic [2:0] {INIT, SHUFFLE, IDLE, DEAL, ONE, EMPTY} state_t;

   state_t           state, state_nxt;
   logic [15:0]      lfsr;
   logic [51:0][3:0] deck;
   logic [5:0]       ptr, idx, j;
   logic [1:0]       deal_n;
   logic [2:0]       gap_cnt;
   logic             hit_q, hit_pend, dhit_pend, one_p;
   logic             emit, swap, last, into_init;
   logic             hit_set, dhit_set, hit_clr, dhit_clr;

   assign j         = lfsr[5:0];
   assign swap      = (state == SHUFFLE) && (j <= idx);
   assign last      = (ptr == 6'd51);
   assign into_init = (state != INIT) && (state_nxt == INIT);

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      case (state)
         INIT:    state_nxt = SHUFFLE;
         SHUFFLE: if (swap && idx == 6'd1) state_nxt = IDLE;
         IDLE: begin
            if (bus.shuffle)                state_nxt = INIT;
            else if (bus.deal)              state_nxt = DEAL;
            else if (hit_pend || dhit_pend) state_nxt = ONE;
         end
         DEAL: begin
            if (gap_cnt == 3'd0) begin
               emit = 1'b1;
               if (last)                 state_nxt = EMPTY;
               else if (deal_n == 2'd3)  state_nxt = IDLE;
            end
         end
         ONE: begin
            emit      = 1'b1;
            state_nxt = last ? EMPTY : IDLE;
         end
         EMPTY:   if (bus.shuffle) state_nxt = INIT;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= INIT;
      else       state <= state_nxt;
   end

   // Request capture is suppressed in EMPTY; entering INIT flushes anything queued.
   assign hit_set  = bus.hit && !hit_q && (state != EMPTY);
   assign dhit_set = bus.dhit && (state != EMPTY);
   assign hit_clr  = into_init || (state == ONE && one_p);
   assign dhit_clr = into_init || (state == ONE && !one_p);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr      <= SEED;
         ptr       <= 6'd0;
         idx       <= 6'd51;
         deal_n    <= 2'd0;
         gap_cnt   <= 3'd0;
         hit_q     <= 1'b0;
         hit_pend  <= 1'b0;
         dhit_pend <= 1'b0;
         one_p     <= 1'b0;
      end else begin
         lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         hit_q     <= bus.hit;
         hit_pend  <= (hit_pend & ~hit_clr) | (hit_set & ~into_init);
         dhit_pend <= (dhit_pend & ~dhit_clr) | (dhit_set & ~into_init);
         if (into_init) ptr <= 6'd0;
         else if (emit) ptr <= ptr + 6'd1;
         case (state)
            INIT:    idx <= 6'd51;
            SHUFFLE: if (swap) idx <= idx - 6'd1;
            IDLE: begin
               deal_n  <= 2'd0;
               gap_cnt <= 3'd0;
               one_p   <= hit_pend;
            end
            DEAL: begin
               if (gap_cnt == 3'd0) begin
                  gap_cnt <= 3'(GAP);
                  deal_n  <= deal_n + 2'd1;
               end else begin
                  gap_cnt <= gap_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Deck contents are fully rewritten in INIT, so they need no reset.
   always_ff @(posedge clock) begin
      if (state == INIT) begin
         for (int k = 0; k < 52; k++)
            deck[k] <= (k % 13 >= 9) ? 4'd10 : 4'(k % 13 + 1);
      end else if (swap) begin
         deck[idx] <= deck[j];
         deck[j]   <= deck[idx];
      end
   end

   assign bus.card      = emit ? deck[ptr] : 4'd0;
   assign bus.ready     = (state == IDLE);
   assign bus.empty     = (state == EMPTY);
   assign bus.remaining = 6'd52 - ptr - {5'd0, emit};
endmodule
